// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry registered skid buffer between the execute and
// memory stages. Holds the execute result plus write-back/memory control
// bits and hands them on under a valid/ready handshake. in_ready comes
// from flops only, which gives full throughput with no combinational
// out_ready -> in_ready path. Supports flush and a sticky halt.
module ex_mem_skid #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic [DW-1:0] in_st_data,
    input  logic [RW-1:0] in_rd,
    input  logic          in_reg_wr,
    input  logic          in_mem_rd,
    input  logic          in_mem_wr,
    input  logic          in_halt,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [DW-1:0] out_st_data,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_wr,
    output logic          out_mem_rd,
    output logic          out_mem_wr,
    output logic          out_halt,
    output logic          halted
);

    // Packed beat layout: {result, st_data, rd, reg_wr, mem_rd, mem_wr, halt}
    localparam int BW = 2*DW + RW + 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t          state;
    logic          halted_q;
    logic [BW-1:0] main_beat;
    logic [BW-1:0] skid_beat;
    logic [BW-1:0] in_beat;
    logic          accept;
    logic          pop;

    assign in_beat = {in_result, in_st_data, in_rd,
                      in_reg_wr, in_mem_rd, in_mem_wr, in_halt};

    // The skid is only occupied in TWO, so intake readiness is a pure flop decode.
    assign in_ready  = (state != TWO) && !halted_q;
    assign out_valid = (state != EMPTY);
    assign halted    = halted_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Occupancy FSM, sticky halt and payload movement; flush overrides accept/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            halted_q  <= 1'b0;
            main_beat <= '0;
            skid_beat <= '0;
        end else if (flush) begin
            // Payload is left as-is; only occupancy and halt are cleared.
            state    <= EMPTY;
            halted_q <= 1'b0;
        end else begin
            if (accept && in_halt) begin
                halted_q <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_beat <= in_beat;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_beat <= in_beat;
                    end else if (accept) begin
                        skid_beat <= in_beat;
                        state     <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move things.
                    if (pop) begin
                        main_beat <= skid_beat;
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Head payload straight from the main register; control bits gated by valid.
    assign out_result  = main_beat[BW-1 -: DW];
    assign out_st_data = main_beat[BW-DW-1 -: DW];
    assign out_rd      = main_beat[4 +: RW];
    assign out_reg_wr  = main_beat[3] && out_valid;
    assign out_mem_rd  = main_beat[2] && out_valid;
    assign out_mem_wr  = main_beat[1] && out_valid;
    assign out_halt    = main_beat[0] && out_valid;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Testbench for ex_mem_skid: directed scenarios plus a random stall phase,
// with a queue scoreboard checked at every falling edge.
module tb_ex_mem_skid;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int BW = 2*DW + RW + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic [DW-1:0] in_st_data;
    logic [RW-1:0] in_rd;
    logic          in_reg_wr, in_mem_rd, in_mem_wr, in_halt;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_st_data;
    logic [RW-1:0] out_rd;
    logic          out_reg_wr, out_mem_rd, out_mem_wr, out_halt;
    logic          halted;

    ex_mem_skid #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_st_data(in_st_data), .in_rd(in_rd),
        .in_reg_wr(in_reg_wr), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .in_halt(in_halt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_st_data(out_st_data), .out_rd(out_rd),
        .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_halt(out_halt), .halted(halted)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [BW-1:0] q[$];
    logic          m_halted = 1'b0;

    wire [BW-1:0] out_beat = {out_result, out_st_data, out_rd,
                              out_reg_wr, out_mem_rd, out_mem_wr, out_halt};
    wire [BW-1:0] in_beat  = {in_result, in_st_data, in_rd,
                              in_reg_wr, in_mem_rd, in_mem_wr, in_halt};
    wire [3:0]    out_ctrl = {out_reg_wr, out_mem_rd, out_mem_wr, out_halt};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare against queue head, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic exp_v, exp_rdy, acc, pp;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_beat", out_beat, '0);
            q.delete();
            m_halted = 1'b0;
        end else begin
            exp_v   = (q.size() != 0);
            exp_rdy = (q.size() < 2) && !m_halted;
            chk("out_valid", out_valid, exp_v);
            if (exp_v) chk("out_beat", out_beat, q[0]);
            else       chk("ctrl_gated", out_ctrl, 4'h0);
            chk("in_ready", in_ready, exp_rdy);
            chk("halted", halted, m_halted);
            if (flush) begin
                q.delete();
                m_halted = 1'b0;
            end else begin
                pp  = exp_v && out_ready;
                acc = in_valid && exp_rdy;
                if (pp) void'(q.pop_front());
                if (acc) begin
                    q.push_back(in_beat);
                    if (in_halt) m_halted = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [DW-1:0] r, input logic h);
        in_valid   = v;
        in_result  = r;
        in_st_data = ~r;
        in_rd      = r[RW-1:0];
        in_reg_wr  = r[0];
        in_mem_rd  = r[1];
        in_mem_wr  = r[2];
        in_halt    = h;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 16'h0000, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_beat", out_beat, '0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_halted", halted, 1'b0);

        // Streaming: each beat visible right after the edge that accepts it
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, DW'(i), 1'b0);
            cyc();
            chk("stream_result", out_result, DW'(i));
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_in_ready", in_ready, 1'b1);
        end
        offer(1'b0, 16'h0000, 1'b0);
        cyc(); cyc();

        // Backpressure
        out_ready = 1'b0;
        offer(1'b1, 16'hA000, 1'b0); cyc();
        offer(1'b1, 16'hA001, 1'b0); cyc();
        chk("bp_in_ready_low", in_ready, 1'b0);
        offer(1'b1, 16'hA002, 1'b0); cyc(); cyc();
        chk("bp_head_held", out_result, 16'hA000);
        out_ready = 1'b1;
        cyc();
        chk("bp_second", out_result, 16'hA001);
        cyc();
        chk("bp_third", out_result, 16'hA002);
        offer(1'b0, 16'h0000, 1'b0);
        cyc(); cyc();

        // Flush in TWO with a beat offered in the same cycle
        out_ready = 1'b0;
        offer(1'b1, 16'hB000, 1'b0); cyc();
        offer(1'b1, 16'hB001, 1'b0); cyc();
        offer(1'b1, 16'hB002, 1'b0); flush = 1'b1; cyc();
        flush = 1'b0; offer(1'b0, 16'h0000, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cyc(); cyc();

        // Halt
        offer(1'b1, 16'h00FF, 1'b1); cyc();
        offer(1'b1, 16'h0100, 1'b0);
        chk("halt_result", out_result, 16'h00FF);
        chk("halt_out_halt", out_halt, 1'b1);
        chk("halt_halted", halted, 1'b1);
        chk("halt_in_ready", in_ready, 1'b0);
        cyc(); cyc(); cyc();
        chk("halt_no_more", out_valid, 1'b0);
        offer(1'b0, 16'h0000, 1'b0);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("halt_flush_halted", halted, 1'b0);
        chk("halt_flush_in_ready", in_ready, 1'b1);

        // Async reset in TWO, asserted between edges
        out_ready = 1'b0;
        offer(1'b1, 16'hC000, 1'b0); cyc();
        offer(1'b1, 16'hC001, 1'b0); cyc();
        offer(1'b0, 16'h0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 1'b0);
        chk("areset_out_beat", out_beat, '0);
        cyc();
        rst_n = 1'b1;
        chk("areset_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cyc();

        // Random stall/valid traffic against the scoreboard
        for (int i = 0; i < 1000; i++) begin
            offer($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 63) == 0);
            in_st_data = DW'($urandom);
            out_ready  = $urandom_range(0, 3) != 0;
            flush      = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            cyc();
        end
        offer(1'b0, 16'h0000, 1'b0);
        flush = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
